kronos_prefetch: RTL and testbench
==================================

Name: kronos_prefetch

Overview:
- Sequential instruction prefetch buffer between the core's instruction port (instr_addr/instr_data/instr_req/instr_gnt) and the instruction memory bus.
- Fetches ahead from the last fetch address into a DEPTH-entry FIFO and serves core requests on a head-address match.
- On an address mismatch (branch/jump), it flushes and redirects fetch.
- Presents to the core the same req/gnt protocol as memory, so it drops in on the fetch path.

Parameters:
DEPTH, 4, FIFO entries; power of two, >=2
BOOT_ADDR, 32'h0, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-high
core_addr  in  32  core fetch address, word aligned, bits [1:0] ignored
core_req  in  1  core fetch request
core_gnt  out  1  core_data valid for core_addr this cycle
core_data  out  32  instruction word
mem_addr  out  32  memory fetch address
mem_req  out  1  memory request
mem_gnt  in  1  memory grant; mem_data valid this cycle
mem_data  in  32  memory read data

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: state=IDLE, count=0, head_addr=fetch_addr=BOOT_ADDR, mem_req=0, mem_addr=BOOT_ADDR, core_gnt=0. FIFO storage is not reset; core_data is don't-care while core_gnt=0.
- State machine:
  - IDLE -> RUN unconditionally, one cycle after reset release.
  - RUN -> DISCARD on a redirect while a memory request is outstanding and not granted that cycle.
  - DISCARD -> RUN on mem_gnt.
  - rst from any state returns to IDLE next edge and drops the outstanding request.
- Memory side:
  - In RUN, mem_req=1 when count<DEPTH; mem_addr=fetch_addr.
  - Once mem_req is raised, mem_req and mem_addr hold stable until mem_gnt, even across a redirect.
  - RUN and mem_gnt: push mem_data, fetch_addr+=4 (wraps mod 2^32).
  - Single-cycle grant protocol: at most one request outstanding.
- Core side (combinational):
  - hit = core_req && count!=0 && core_addr[31:2]==head_addr[31:2].
  - core_gnt=hit; core_data=FIFO head.
  - On hit: pop, head_addr+=4 (wraps).
- Waiting:
  - core_req with count==0 and address equal to head_addr is not a miss; core_gnt stays 0 until data arrives.
  - Push and pop in the same cycle leave count unchanged. A push at count==DEPTH cannot occur because mem_req is gated.
- Redirect: core_req && core_addr[31:2]!=head_addr[31:2], in RUN or DISCARD.
  - Next edge: count=0, head_addr=fetch_addr=core_addr&~3.
  - If mem_req is high and mem_gnt is low that cycle: enter DISCARD. The old request is still completed, its data is dropped, and fetch_addr is not incremented.
  - If mem_gnt coincides with the redirect: the returned data is dropped and the block stays in RUN.
  - A further redirect while in DISCARD updates head_addr/fetch_addr and stays in DISCARD.
  - core_gnt=0 on every redirect cycle.
- Latency: with an empty FIFO, core_gnt rises the cycle after the matching mem_gnt (push then pop). With a full FIFO and no bubbles, throughput is 1 word/cycle.

Optional Feature:
- Macro: KRONOS_PREFETCH_BYPASS_EN.
- Defined: when count==0, in RUN, with mem_gnt, core_req, and core_addr[31:2]==fetch_addr[31:2]==head_addr[31:2], mem_data forwards to core_data with core_gnt=1 that same cycle. There is no FIFO write; head_addr and fetch_addr both advance by 4. Empty-FIFO latency becomes 0 extra cycles.
- Undefined: always push first; empty-FIFO latency is +1 cycle.

Test Plan:
- Boot stream: BOOT_ADDR=0, mem_gnt always 1, core_req on 0,4,8,... -> IDLE one cycle, then mem_addr=0,4,8; first core_gnt the cycle after mem_addr=0 is granted (same cycle with BYPASS_EN); then one core_gnt per cycle with data matching each address.
- Fill/stall: core_req=0 for 10 cycles -> exactly DEPTH=4 grants, mem_req drops at count=4. Resuming core_req at 0 -> four back-to-back core_gnt with no memory bubble needed.
- Redirect with outstanding request: mem_req high at 0x10, mem_gnt held low 3 cycles, core_addr=0x100 -> DISCARD, mem_addr stays 0x10 until grant, data dropped. Next mem_addr=0x100; core_gnt returns data of 0x100 only.
- Redirect coincident with mem_gnt: core_addr=0x40 while 0x20 is granted -> 0x20 data dropped, stays RUN, next mem_addr=0x40.
- Wrap-around: redirect to 0xFFFFFFF8 -> mem_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; core hits in that order.
- Mid-operation reset: rst pulsed with count=3 and mem_req pending -> next cycle core_gnt=0, mem_req=0, mem_addr=BOOT_ADDR; the stream restarts from BOOT_ADDR.

Source files
------------

// File: rtl/kronos_prefetch.sv
// ---------------------------------------------------------------------------
// kronos_prefetch
//
// Sequential instruction prefetch buffer. It sits between the core's fetch
// port and the instruction memory bus. It fetches ahead from the last fetch
// address into a DEPTH-entry FIFO and serves core requests whose address
// matches the FIFO head. When the core asks for any other address (a branch
// or jump), the buffer flushes and redirects fetching. The core sees the
// same req/gnt protocol as the memory bus.
//
// Optional feature macro: KRONOS_PREFETCH_BYPASS_EN
//   When defined, the FIFO is empty and the core asks for the word being
//   granted this cycle: mem_data goes straight to core_data, with core_gnt
//   asserted in the same cycle.
//
// Parameters:
//   DEPTH      FIFO entries (power of two, >= 2)
//   BOOT_ADDR  first fetch address after reset
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   core_addr  core fetch address (bits [1:0] ignored)
//   core_req   core fetch request
//   core_gnt   core_data valid for core_addr this cycle (combinational)
//   core_data  instruction word
//   mem_addr   memory fetch address (registered)
//   mem_req    memory request (registered)
//   mem_gnt    memory grant, mem_data valid this cycle
//   mem_data   memory read data
// ---------------------------------------------------------------------------
module kronos_prefetch #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr,
    input  logic        core_req,
    output logic        core_gnt,
    output logic [31:0] core_data,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_gnt,
    input  logic [31:0] mem_data
);

    localparam int unsigned   PW         = $clog2(DEPTH);
    localparam int unsigned   CW         = PW + 1;
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    logic [1:0]    state_r,      state_nxt_s;
    logic [CW-1:0] count_r,      count_nxt_s;
    logic [31:0]   head_addr_r,  head_nxt_s;
    logic [31:0]   fetch_addr_r, fetch_nxt_s;
    logic          mem_req_r,    mem_req_nxt_s;
    logic [31:0]   mem_addr_r,   mem_addr_nxt_s;
    logic [PW-1:0] rd_ptr_r,     wr_ptr_r;
    logic [31:0]   fifo_mem_r [DEPTH];

    logic [31:0] core_word_s;
    logic        head_match_s;
    logic        active_s;
    logic        redirect_s;
    logic        granted_s;
    logic        waiting_s;
    logic        bypass_s;
    logic        hit_s;
    logic        push_s;
    logic        pop_s;

    // Request/hit/redirect decode for the current cycle
    always_comb begin
        core_word_s  = core_addr & 32'hFFFF_FFFC;
        head_match_s = (core_word_s[31:2] == head_addr_r[31:2]);
        active_s     = (state_r == ST_RUN) || (state_r == ST_DISCARD);
        redirect_s   = active_s && core_req && !head_match_s;
        granted_s    = mem_req_r && mem_gnt;
        // A raised request must hold address and req until it is granted
        waiting_s    = mem_req_r && !mem_gnt;
`ifdef KRONOS_PREFETCH_BYPASS_EN
        bypass_s     = (state_r == ST_RUN) && (count_r == {CW{1'b0}}) && granted_s &&
                       core_req && head_match_s &&
                       (core_word_s[31:2] == fetch_addr_r[31:2]);
`else
        bypass_s     = 1'b0;
`endif
        hit_s        = core_req && head_match_s && ((count_r != {CW{1'b0}}) || bypass_s);
        pop_s        = hit_s && !bypass_s;
        // Data arriving on a redirect cycle or in DISCARD belongs to a stale stream
        push_s       = (state_r == ST_RUN) && granted_s && !redirect_s && !bypass_s;
    end

    // Core-side outputs are combinational so a head hit is served in-cycle
    always_comb begin
        core_gnt  = hit_s;
        if (bypass_s) begin
            core_data = mem_data;
        end else begin
            core_data = fifo_mem_r[rd_ptr_r];
        end
    end

    // Next-state computation for control state, addresses and memory request
    always_comb begin
        state_nxt_s    = state_r;
        count_nxt_s    = count_r;
        head_nxt_s     = head_addr_r;
        fetch_nxt_s    = fetch_addr_r;
        mem_req_nxt_s  = mem_req_r;
        mem_addr_nxt_s = mem_addr_r;

        case (state_r)
            ST_IDLE: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_s && waiting_s) begin
                    state_nxt_s = ST_DISCARD;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DISCARD: begin
                // The stale request completes here; a redirect does not extend it
                if (mem_gnt) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_DISCARD;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        if (redirect_s) begin
            count_nxt_s = {CW{1'b0}};
            head_nxt_s  = core_word_s;
            fetch_nxt_s = core_word_s;
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CW'(1);
                2'b01:   count_nxt_s = count_r - CW'(1);
                default: count_nxt_s = count_r;
            endcase
            if (hit_s) begin
                head_nxt_s = head_addr_r + 32'd4;
            end else begin
                head_nxt_s = head_addr_r;
            end
            // Bypassed words advance the fetch pointer even though nothing is pushed
            if ((state_r == ST_RUN) && granted_s) begin
                fetch_nxt_s = fetch_addr_r + 32'd4;
            end else begin
                fetch_nxt_s = fetch_addr_r;
            end
        end

        // Request is computed from next-cycle state so back-to-back grants stream
        if (waiting_s) begin
            mem_req_nxt_s  = mem_req_r;
            mem_addr_nxt_s = mem_addr_r;
        end else begin
            mem_req_nxt_s  = (state_nxt_s == ST_RUN) && (count_nxt_s < COUNT_FULL);
            mem_addr_nxt_s = fetch_nxt_s;
        end
    end

    // Control and address registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            count_r      <= {CW{1'b0}};
            head_addr_r  <= BOOT_ADDR;
            fetch_addr_r <= BOOT_ADDR;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= BOOT_ADDR;
            rd_ptr_r     <= {PW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
        end else begin
            state_r      <= state_nxt_s;
            count_r      <= count_nxt_s;
            head_addr_r  <= head_nxt_s;
            fetch_addr_r <= fetch_nxt_s;
            mem_req_r    <= mem_req_nxt_s;
            mem_addr_r   <= mem_addr_nxt_s;
            if (redirect_s) begin
                rd_ptr_r <= wr_ptr_r;
            end else begin
                if (push_s) begin
                    wr_ptr_r <= wr_ptr_r + PW'(1);
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PW'(1);
                end
            end
        end
    end

    // FIFO storage write port (storage itself is not reset)
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            fifo_mem_r[wr_ptr_r] <= mem_data;
        end
    end

    assign mem_req  = mem_req_r;
    assign mem_addr = mem_addr_r;

endmodule

// File: tb/tb_kronos_prefetch.sv
// ---------------------------------------------------------------------------
// Self-checking bench for kronos_prefetch. A queue-based behavioural model of
// the prefetcher predicts mem_req/mem_addr/core_gnt/core_data every cycle
// under randomized grant, request and redirect stimulus, organised in phases
// (fill/stall, drain, wrap redirect, stalled redirect, coincident redirect,
// mid-run reset, random mix).
// ---------------------------------------------------------------------------
module tb_kronos_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] BOOT  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] core_addr;
    logic        core_req;
    logic        core_gnt;
    logic [31:0] core_data;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    kronos_prefetch #(.DEPTH(DEPTH), .BOOT_ADDR(BOOT)) dut (
        .clk       (clk),
        .rst       (rst),
        .core_addr (core_addr),
        .core_req  (core_req),
        .core_gnt  (core_gnt),
        .core_data (core_data),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_data  (mem_data)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: 0=IDLE 1=RUN 2=DISCARD, words held in a queue
    int          m_state;
    logic [31:0] q[$];
    logic [31:0] m_head, m_fetch, m_addr;
    logic        m_req;
    logic [31:0] tb_pc;
    logic [31:0] targets [4];

    task automatic model_reset();
        m_state = 0;
        q.delete();
        m_head  = BOOT;
        m_fetch = BOOT;
        m_req   = 1'b0;
        m_addr  = BOOT;
        tb_pc   = BOOT;
    endtask

    task automatic model_step(input logic hit, input logic byp, input logic redir);
        logic granted;
        logic stalled;
        granted = m_req && mem_gnt;
        stalled = m_req && !mem_gnt;
        if (m_state == 0) begin
            m_state = 1;
        end else if (redir) begin
            q.delete();
            m_head  = core_addr & 32'hFFFF_FFFC;
            m_fetch = m_head;
            m_state = stalled ? 2 : 1;
        end else if (m_state == 2) begin
            if (granted) m_state = 1;
        end else begin
            if (hit && !byp) void'(q.pop_front());
            if (hit) m_head = m_head + 32'd4;
            if (granted) begin
                if (!byp) q.push_back(mem_data);
                m_fetch = m_fetch + 32'd4;
            end
        end
        if (!stalled) begin
            m_req  = (m_state == 1) && (q.size() < DEPTH);
            m_addr = m_fetch;
        end
    endtask

    task automatic run_cycle(input int gnt_pct, input int req_pct, input int redir_pct,
                             input int tgt_sel, input logic do_rst);
        logic word_eq, byp, hit, redir;
        logic [31:0] exp_data;
        int   sel;
        @(negedge clk);
        rst      = do_rst;
        mem_gnt  = m_req && ($urandom_range(99) < gnt_pct);
        mem_data = mem_gnt ? mem_word(m_addr) : $urandom;
        core_req = ($urandom_range(99) < req_pct);
        if (core_req && ($urandom_range(99) < redir_pct)) begin
            sel = (tgt_sel >= 0) ? tgt_sel : int'($urandom_range(4));
            if (sel < 4) tb_pc = targets[sel];
            else         tb_pc = $urandom & 32'hFFFF_FFFC;
        end
        core_addr = tb_pc | 32'($urandom_range(3));
        #1;
        word_eq = (core_addr[31:2] == m_head[31:2]);
        byp = 1'b0;
`ifdef KRONOS_PREFETCH_BYPASS_EN
        byp = (m_state == 1) && (q.size() == 0) && mem_gnt && core_req && word_eq &&
              (core_addr[31:2] == m_fetch[31:2]);
`endif
        hit   = core_req && word_eq && ((q.size() != 0) || byp);
        redir = (m_state != 0) && core_req && !word_eq;
        check_val("mem_req",  {31'd0, mem_req},  {31'd0, m_req});
        check_val("mem_addr", mem_addr, m_addr);
        check_val("core_gnt", {31'd0, core_gnt}, {31'd0, hit});
        if (hit) begin
            exp_data = byp ? mem_data : q[0];
            check_val("core_data", core_data, exp_data);
            check_val("core_data_addr", core_data, mem_word(m_head));
        end
        if (do_rst) begin
            model_reset();
        end else begin
            model_step(hit, byp, redir);
            if (hit) tb_pc = tb_pc + 32'd4;
        end
    endtask

    // Phase table: cycles, grant %, request %, redirect %, target (-1 random), reset
    localparam int NPH = 12;
    int ph_cyc [NPH] = '{10, 12,   1, 12,   1,  3, 10,   1, 10,   1, 20, 700};
    int ph_gnt [NPH] = '{100,100, 100,100,   0,  0,100, 100,100, 100,100,  60};
    int ph_req [NPH] = '{0,  100, 100,100, 100,100,100, 100,100,  60,100,  80};
    int ph_red [NPH] = '{0,    0, 100,  0, 100,  0,  0, 100,  0,   0,  0,  12};
    int ph_tgt [NPH] = '{-1,  -1,   2, -1,   0, -1, -1,   1, -1,  -1, -1,  -1};
    int ph_rst [NPH] = '{0,    0,   0,  0,   0,  0,  0,   0,  0,   1,  0,   0};

    initial begin
        targets[0] = 32'h0000_0100;
        targets[1] = 32'h0000_0040;
        targets[2] = 32'hFFFF_FFF8;
        targets[3] = 32'h0000_0010;
        rst       = 1'b1;
        core_req  = 1'b0;
        core_addr = 32'h0;
        mem_gnt   = 1'b0;
        mem_data  = 32'h0;
        repeat (2) @(posedge clk);
        model_reset();
        @(negedge clk);
        check_val("reset_mem_req",  {31'd0, mem_req},  32'd0);
        check_val("reset_mem_addr", mem_addr, BOOT);
        check_val("reset_core_gnt", {31'd0, core_gnt}, 32'd0);

        for (int p = 0; p < NPH; p++) begin
            for (int c = 0; c < ph_cyc[p]; c++) begin
                run_cycle(ph_gnt[p], ph_req[p], ph_red[p], ph_tgt[p], ph_rst[p] != 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
